cmd_response_encoder: RTL
=========================

Name: cmd_response_encoder

Overview:
- Builds the Ethernet response frame the FPGA returns to the host after the command decoder executes a command.
- Accepts one response descriptor plus an optional 32-bit payload word stream.
- Serialises the frame as an 8-bit AXI-Stream toward the tri-mode MAC TX FIFO: host/FPGA MAC header, length, sequence, command echo, status, little-endian payload, then zero padding to the 60-byte minimum.
- Sits beside cmd_decoder_top in the gtx_clk_bufg domain.

Parameters:
- HOST_MAC_ADDR, 48'h985aebdb066f: destination MAC, bytes 0-5, MSB byte first.
- FPGA_MAC_ADDR, 48'h5a0102030405: source MAC, bytes 6-11, MSB byte first.
- MAX_WORDS, 64: maximum payload words per frame, range 1..255.

Ports:
- gtx_clk_bufg in 1: the single clock.
- gtx_reset in 1: synchronous, active-high reset.
- rsp_valid in 1: response descriptor valid.
- rsp_ready out 1: descriptor accepted when rsp_valid && rsp_ready.
- rsp_cmd_type in 2: bit0=1 gives 'C' (0x43), bit0=0 gives 'F' (0x46); bit1=1 gives 'W' (0x57), bit1=0 gives 'R' (0x52).
- rsp_cmd_id in 8: command id echoed back.
- rsp_status in 8: status byte.
- rsp_word_count in 8: payload words N.
- pay_tdata in 32: payload word.
- pay_tvalid in 1: payload word valid.
- pay_tready out 1: payload word accepted.
- tx_axis_tdata out 8: frame byte.
- tx_axis_tvalid out 1: frame byte valid.
- tx_axis_tlast out 1: last byte of frame.
- tx_axis_tready in 1: downstream ready.
- frame_sent out 1: one-cycle pulse on the handshake of the tlast byte.

Behaviour:
- Reset values: rsp_ready=0, pay_tready=0, tx_axis_tvalid=0, tx_axis_tlast=0, tx_axis_tdata=0, frame_sent=0, seq=0, state=IDLE.
  - Reset asserted mid-frame aborts at the next edge with no tlast. The MAC discards the truncated frame.
- Descriptor latch:
  - rsp_ready=1 only in IDLE.
  - On handshake, latch type, id, status and Nc = min(rsp_word_count, MAX_WORDS).
  - Go to HDR.
  - The first header byte is presented with tvalid=1 on the next cycle (latency 1).
- Frame layout (byte index):
  - 0-5: HOST_MAC_ADDR.
  - 6-11: FPGA_MAC_ADDR.
  - 12-13: length L = 10 + 4*Nc, big-endian.
  - 14-15: seq, little-endian.
  - 16-17: type char, repeated.
  - 18-19: op char, repeated.
  - 20: cmd_id.
  - 21: status.
  - 22-23: Nc, little-endian 16-bit.
  - 24 onward: payload words, each sent byte[7:0] first.
  - Then zero bytes until total length is 60.
  - Total length = max(24 + 4*Nc, 60). Padding occurs only for Nc <= 8.
- States: IDLE, HDR, PAYLOAD, PAD.
  - HDR leaves after byte 23 handshakes: to PAYLOAD if Nc>0, else to PAD.
  - PAYLOAD leaves after the last byte of word Nc: to PAD if total < 60, else back to IDLE.
  - PAD returns to IDLE after byte 59.
- AXI-S rules:
  - Advance only on tvalid && tready.
  - tdata and tlast are held stable while tready=0.
  - tlast=1 exactly on the final byte (last payload byte or byte 59).
  - Back-to-back frames: IDLE lasts one cycle, so there is at least one idle cycle between frames.
- Payload buffering: one 32-bit word register plus 2-bit byte_idx.
  - pay_tready = (state==PAYLOAD) && (words_taken < Nc) && (!word_valid || (byte_idx==3 && tx_axis_tready)).
  - This gives no bubble when pay_tvalid is held high.
  - If the payload starves, tx_axis_tvalid drops mid-payload. Upstream guarantees words are prefetched; the encoder does not stall-fill.
  - Words beyond Nc are never accepted, so upstream must discard any excess beyond the clamp.
- Sequence counter: 16-bit, increments on frame_sent, wraps 0xFFFF to 0x0000.
- Width rules:
  - L is computed in 16 bits.
  - byte counter is 11 bits (max 24+4*255 = 1044).

Test Plan:
- Read response: type=2'b01, id=0x04, status=0x00, N=1, word 0xfeedbeef -> 60 bytes. Bytes 12-13=00 0e, 16-19=43 43 52 52, 20=04, 24-27=ef be ed fe, 28-59=00; tlast on byte 59; frame_sent pulse; seq then =1.
- Write ack: type=2'b11, id=0xce, N=0 -> bytes 12-13=00 0a, 16-19=43 43 57 57, 20=ce, 22-23=00 00, bytes 24-59 zero, total 60.
- Long frame: N=16 with words 0..15 -> total 88 bytes, L=0x004a, no padding, pay_tready accepts exactly 16 words, tlast on byte 87. Clamp check: N=200 with MAX_WORDS=64 gives Nc=64, L=0x010a, total 280.
- Backpressure: toggle tx_axis_tready randomly (50%) during an N=16 frame -> byte stream identical to the no-stall run, with no duplicated or dropped bytes.
- Sequence wrap: force 65537 frames (or preload seq to 0xFFFF) -> seq bytes ff ff, then 00 00.
- Reset at byte 30 of an N=16 frame -> next cycle tvalid=0, tlast=0, seq=0, rsp_ready=1 one cycle after reset deasserts; the next frame starts at byte 0.

Source files
------------

// File: rtl/cmd_response_encoder.sv
// cmd_response_encoder: serialises one command-response descriptor and its
// optional 32-bit payload words into an 8-bit AXI-Stream Ethernet frame for
// the MAC TX FIFO. The frame is padded with zero bytes to the 60-byte minimum.
module cmd_response_encoder #(
  parameter logic [47:0] HOST_MAC_ADDR = 48'h985aebdb066f,
  parameter logic [47:0] FPGA_MAC_ADDR = 48'h5a0102030405,
  parameter int unsigned MAX_WORDS     = 64
) (
  input  logic        gtx_clk_bufg,
  input  logic        gtx_reset,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [1:0]  rsp_cmd_type,
  input  logic [7:0]  rsp_cmd_id,
  input  logic [7:0]  rsp_status,
  input  logic [7:0]  rsp_word_count,
  input  logic [31:0] pay_tdata,
  input  logic        pay_tvalid,
  output logic        pay_tready,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  output logic        frame_sent
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] PAD     = 2'd3;

  localparam logic [7:0] MAX_WORDS_B = 8'(MAX_WORDS);

  // Limit the requested word count to what one frame may carry.
  function automatic logic [7:0] clamp_words(input logic [7:0] wc);
    return (wc > MAX_WORDS_B) ? MAX_WORDS_B : wc;
  endfunction

  // Index of the final byte: max(24 + 4*nc, 60) - 1.
  function automatic logic [10:0] frame_last_idx(input logic [7:0] nc);
    logic [10:0] total;
    total = 11'd24 + {1'b0, nc, 2'b00};
    if (total < 11'd60) total = 11'd60;
    return total - 11'd1;
  endfunction

  // Header byte at a given index; every index past the header is a zero pad byte.
  function automatic logic [7:0] hdr_byte(input logic [10:0] idx,
                                          input logic [1:0]  ty,
                                          input logic [7:0]  id,
                                          input logic [7:0]  st,
                                          input logic [7:0]  nc,
                                          input logic [15:0] sq);
    logic [15:0] len;
    logic [7:0]  b;
    len = 16'd10 + {6'd0, nc, 2'b00};
    b   = 8'h00;
    case (idx)
      11'd0:  b = HOST_MAC_ADDR[47:40];
      11'd1:  b = HOST_MAC_ADDR[39:32];
      11'd2:  b = HOST_MAC_ADDR[31:24];
      11'd3:  b = HOST_MAC_ADDR[23:16];
      11'd4:  b = HOST_MAC_ADDR[15:8];
      11'd5:  b = HOST_MAC_ADDR[7:0];
      11'd6:  b = FPGA_MAC_ADDR[47:40];
      11'd7:  b = FPGA_MAC_ADDR[39:32];
      11'd8:  b = FPGA_MAC_ADDR[31:24];
      11'd9:  b = FPGA_MAC_ADDR[23:16];
      11'd10: b = FPGA_MAC_ADDR[15:8];
      11'd11: b = FPGA_MAC_ADDR[7:0];
      11'd12: b = len[15:8];
      11'd13: b = len[7:0];
      11'd14: b = sq[7:0];
      11'd15: b = sq[15:8];
      11'd16, 11'd17: b = ty[0] ? 8'h43 : 8'h46;
      11'd18, 11'd19: b = ty[1] ? 8'h57 : 8'h52;
      11'd20: b = id;
      11'd21: b = st;
      11'd22: b = nc;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [1:0]  state;
  logic [15:0] seq;
  logic        rdy_q;
  logic [10:0] byte_cnt;
  logic [1:0]  byte_idx;
  logic        word_valid;
  logic [7:0]  words_taken;

  logic [1:0]  type_q;
  logic [7:0]  id_q;
  logic [7:0]  status_q;
  logic [7:0]  nc_q;
  logic [10:0] last_idx;
  logic [31:0] word_q;

  logic        rsp_fire;
  logic        tx_fire;
  logic        pay_fire;

  assign rsp_ready  = rdy_q;
  assign rsp_fire   = rsp_valid && rdy_q;
  assign tx_fire    = tx_axis_tvalid && tx_axis_tready;
  assign pay_tready = (state == PAYLOAD) && (words_taken < nc_q) &&
                      (!word_valid || ((byte_idx == 2'd3) && tx_axis_tready));
  assign pay_fire   = pay_tvalid && pay_tready;
  assign frame_sent = tx_fire && tx_axis_tlast;

  // Output byte select: header/pad bytes from the index, payload bytes from the word register.
  always_comb begin
    tx_axis_tvalid = 1'b0;
    tx_axis_tdata  = 8'h00;
    case (state)
      HDR, PAD: begin
        tx_axis_tvalid = 1'b1;
        tx_axis_tdata  = hdr_byte(byte_cnt, type_q, id_q, status_q, nc_q, seq);
      end
      PAYLOAD: begin
        tx_axis_tvalid = word_valid;
        case (byte_idx)
          2'd0:    tx_axis_tdata = word_q[7:0];
          2'd1:    tx_axis_tdata = word_q[15:8];
          2'd2:    tx_axis_tdata = word_q[23:16];
          default: tx_axis_tdata = word_q[31:24];
        endcase
      end
      default: ;
    endcase
    tx_axis_tlast = tx_axis_tvalid && (byte_cnt == last_idx);
  end

  // Descriptor fields and the payload word register (no reset needed).
  always_ff @(posedge gtx_clk_bufg) begin
    if (rsp_fire) begin
      type_q   <= rsp_cmd_type;
      id_q     <= rsp_cmd_id;
      status_q <= rsp_status;
      nc_q     <= clamp_words(rsp_word_count);
      last_idx <= frame_last_idx(clamp_words(rsp_word_count));
    end
    if (pay_fire) word_q <= pay_tdata;
  end

  // Frame sequencing FSM, byte counters and the response sequence number.
  always_ff @(posedge gtx_clk_bufg) begin
    if (gtx_reset) begin
      state       <= IDLE;
      seq         <= 16'h0000;
      rdy_q       <= 1'b0;
      byte_cnt    <= 11'd0;
      byte_idx    <= 2'd0;
      word_valid  <= 1'b0;
      words_taken <= 8'd0;
    end else begin
      rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          rdy_q <= !rsp_fire;
          if (rsp_fire) begin
            state       <= HDR;
            byte_cnt    <= 11'd0;
            byte_idx    <= 2'd0;
            word_valid  <= 1'b0;
            words_taken <= 8'd0;
          end
        end
        HDR: begin
          if (tx_fire) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (byte_cnt == 11'd23) state <= (nc_q != 8'd0) ? PAYLOAD : PAD;
          end
        end
        PAYLOAD: begin
          if (tx_fire) begin
            byte_cnt <= byte_cnt + 11'd1;
            byte_idx <= byte_idx + 2'd1;
            if ((byte_idx == 2'd3) && !pay_fire) word_valid <= 1'b0;
            if ((byte_idx == 2'd3) && (words_taken == nc_q)) state <= PAD;
          end
          if (pay_fire) begin
            word_valid  <= 1'b1;
            words_taken <= words_taken + 8'd1;
          end
        end
        default: begin
          if (tx_fire) byte_cnt <= byte_cnt + 11'd1;
        end
      endcase
      // The tlast handshake closes the frame from whichever state carries it.
      if (frame_sent) begin
        state <= IDLE;
        rdy_q <= 1'b1;
        seq   <= seq + 16'd1;
      end
    end
  end

endmodule
